// File: rtl/deserializador_com_align.sv
// Receive-side serial-to-parallel converter: hunts for the COM symbol bit by bit,
// confirms byte phase over LOCK_COUNT aligned COMs, then emits aligned data bytes.
module deserializador_com_align #(
  parameter logic [7:0] COM        = 8'hBC,
  parameter logic [7:0] IDL        = 8'h7C,
  parameter int         LOCK_COUNT = 4
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic       serial_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       byte_strobe,
  output logic       active
);

  localparam logic [3:0] LC = 4'(LOCK_COUNT);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t     r_state, w_state_nx;
  logic [7:0] r_sr, w_sr_next;
  logic [2:0] r_bit_cnt, w_bit_cnt_nx;
  logic [3:0] r_com_cnt, w_com_cnt_nx;
  logic [7:0] r_data, w_data_nx;
  logic       r_valid, w_valid_nx;
  logic       r_strobe, w_strobe_nx;
  logic       r_active, w_active_nx;
  logic       w_boundary, w_is_com, w_is_idl;

  assign w_sr_next  = {r_sr[6:0], serial_in};
  assign w_boundary = (r_bit_cnt == 3'd7);
  assign w_is_com   = (w_sr_next == COM);
  assign w_is_idl   = (w_sr_next == IDL);

  always_ff @(posedge clk_32f) begin
    if (!reset) begin
      r_state   <= SEARCH;
      r_sr      <= 8'h00;
      r_bit_cnt <= 3'd0;
      r_com_cnt <= 4'd0;
      r_data    <= 8'h00;
      r_valid   <= 1'b0;
      r_strobe  <= 1'b0;
      r_active  <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_sr      <= w_sr_next;
      r_bit_cnt <= w_bit_cnt_nx;
      r_com_cnt <= w_com_cnt_nx;
      r_data    <= w_data_nx;
      r_valid   <= w_valid_nx;
      r_strobe  <= w_strobe_nx;
      r_active  <= w_active_nx;
    end
  end

  always_comb begin
    w_state_nx   = r_state;
    w_bit_cnt_nx = r_bit_cnt + 3'd1;
    w_com_cnt_nx = r_com_cnt;
    w_data_nx    = r_data;
    w_valid_nx   = r_valid;
    w_strobe_nx  = 1'b0;
    w_active_nx  = r_active;
    case (r_state)
      SEARCH: begin
        // A COM match here anchors the byte phase: the next boundary is 8 bits on.
        w_bit_cnt_nx = 3'd0;
        if (w_is_com) begin
          w_com_cnt_nx = 4'd1;
          if (LC == 4'd1) begin
            w_state_nx  = LOCKED;
            w_active_nx = 1'b1;
          end else begin
            w_state_nx = SYNC;
          end
        end
      end
      SYNC: begin
        if (w_boundary) begin
          if (w_is_com) begin
            w_com_cnt_nx = r_com_cnt + 4'd1;
            if (r_com_cnt + 4'd1 == LC) begin
              w_state_nx  = LOCKED;
              w_active_nx = 1'b1;
            end
          end else begin
            w_com_cnt_nx = 4'd0;
            w_state_nx   = SEARCH;
          end
        end
      end
      LOCKED: begin
        w_active_nx = 1'b1;
        if (w_boundary) begin
          w_strobe_nx = 1'b1;
          if (w_is_com || w_is_idl) begin
            w_valid_nx = 1'b0;
          end else begin
            w_data_nx  = w_sr_next;
            w_valid_nx = 1'b1;
          end
        end
      end
      default: w_state_nx = SEARCH;
    endcase
  end

  assign data_out    = r_data;
  assign valid_out   = r_valid;
  assign byte_strobe = r_strobe;
  assign active      = r_active;

endmodule

// File: tb/tb_deserializador_com_align.sv
// Bench for deserializador_com_align: bit-indexed reference model checked every
// cycle, plus directed literal expectations and randomized streams.
module tb_deserializador_com_align;

  localparam int LC = 4;

  logic       clk_32f;
  logic       reset;
  logic       serial_in;
  logic [7:0] data_out;
  logic       valid_out;
  logic       byte_strobe;
  logic       active;

  deserializador_com_align #(.COM(8'hBC), .IDL(8'h7C), .LOCK_COUNT(LC)) dut (
    .clk_32f    (clk_32f),
    .reset      (reset),
    .serial_in  (serial_in),
    .data_out   (data_out),
    .valid_out  (valid_out),
    .byte_strobe(byte_strobe),
    .active     (active)
  );

  initial begin
    clk_32f = 1'b0;
    forever #5 clk_32f = ~clk_32f;
  end

  int pass_cnt  = 0;
  int total_cnt = 0;
  bit chk_en    = 0;

  function automatic void check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
  endfunction

  // Reference model: bits counted since reset; phase is the bit index of the
  // COM that ended the hunt, and boundaries are multiples of 8 bits past it.
  int         m_n, m_anchor, m_coms, m_mode;  // mode 0 hunt, 1 confirming, 2 locked
  logic [7:0] m_w, m_data;
  logic       m_valid, m_strobe, m_active;

  task automatic model_step(input logic rst, input logic b);
    if (!rst) begin
      m_n = 0; m_anchor = 0; m_coms = 0; m_mode = 0; m_w = 8'h00;
      m_data = 8'h00; m_valid = 0; m_strobe = 0; m_active = 0;
      return;
    end
    m_n++;
    m_w = {m_w[6:0], b};
    m_strobe = 0;
    if (m_mode == 0) begin
      if (m_w == 8'hBC) begin
        m_anchor = m_n;
        m_coms   = 1;
        if (LC == 1) begin m_mode = 2; m_active = 1; end
        else m_mode = 1;
      end
    end else if (((m_n - m_anchor) % 8) == 0) begin
      if (m_mode == 1) begin
        if (m_w == 8'hBC) begin
          m_coms++;
          if (m_coms == LC) begin m_mode = 2; m_active = 1; end
        end else begin
          m_coms = 0;
          m_mode = 0;
        end
      end else begin
        m_strobe = 1;
        if (m_w == 8'hBC || m_w == 8'h7C) m_valid = 0;
        else begin m_data = m_w; m_valid = 1; end
      end
    end
  endtask

  always @(negedge clk_32f) begin
    if (chk_en) begin
      check("model_data_out",    data_out,           m_data);
      check("model_valid_out",   {7'd0, valid_out},  {7'd0, m_valid});
      check("model_byte_strobe", {7'd0, byte_strobe}, {7'd0, m_strobe});
      check("model_active",      {7'd0, active},     {7'd0, m_active});
    end
  end

  task automatic tick(input logic r, input logic b);
    reset = r;
    serial_in = b;
    @(posedge clk_32f);
    model_step(r, b);
    #1;
  endtask

  task automatic do_reset(input int n);
    repeat (n) tick(1'b0, 1'b0);
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) tick(1'b1, v[i]);
  endtask

  task automatic send_coms(input int n);
    repeat (n) send_byte(8'hBC);
  endtask

  task automatic chk_zero(input string nm);
    check({nm, "_data"},   data_out,             8'h00);
    check({nm, "_valid"},  {7'd0, valid_out},    8'h00);
    check({nm, "_strobe"}, {7'd0, byte_strobe},  8'h00);
    check({nm, "_active"}, {7'd0, active},       8'h00);
  endtask

  logic [7:0] t3_in  [4] = '{8'h7C, 8'h3C, 8'hBC, 8'hFF};
  logic [7:0] t3_dat [4] = '{8'h00, 8'h3C, 8'h3C, 8'hFF};
  logic       t3_val [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

  initial begin
    int n_hits;
    logic [7:0] v, cb;
    reset = 1'b0;
    serial_in = 1'b0;

    // reset then a clean COM stream
    do_reset(2);
    chk_en = 1;
    chk_zero("reset");
    n_hits = 0;
    cb = 8'hBC;
    for (int k = 0; k < 32; k++) begin
      tick(1'b1, cb[7 - (k % 8)]);
      if (k < 31 && (byte_strobe || valid_out || active)) n_hits++;
    end
    check("t1_quiet_before_lock", n_hits[7:0], 8'd0);
    check("t1_active_at_32", {7'd0, active}, 8'd1);
    check("t1_model_active", {7'd0, m_active}, 8'd1);

    // misaligned start
    do_reset(1);
    tick(1'b1, 1'b1); tick(1'b1, 1'b0); tick(1'b1, 1'b1);
    send_coms(3);
    for (int i = 7; i > 0; i--) tick(1'b1, cb[i]);
    check("t2_not_active_at_34", {7'd0, active}, 8'd0);
    tick(1'b1, cb[0]);
    check("t2_active_at_35", {7'd0, active}, 8'd1);
    send_byte(8'hA5);
    check("t2_strobe_at_43", {7'd0, byte_strobe}, 8'd1);
    check("t2_data_a5", data_out, 8'hA5);
    check("t2_valid", {7'd0, valid_out}, 8'd1);
    check("t2_model_data", m_data, 8'hA5);
    tick(1'b1, 1'b0);
    check("t2_strobe_one_cycle", {7'd0, byte_strobe}, 8'd0);

    // idle and COM while locked
    do_reset(1);
    send_coms(4);
    for (int b = 0; b < 4; b++) begin
      send_byte(t3_in[b]);
      check("t3_strobe", {7'd0, byte_strobe}, 8'd1);
      check("t3_data", data_out, t3_dat[b]);
      check("t3_valid", {7'd0, valid_out}, {7'd0, t3_val[b]});
    end

    // broken sync
    do_reset(1);
    send_coms(3);
    send_byte(8'h12);
    check("t4_inactive_after_12", {7'd0, active}, 8'd0);
    send_coms(3);
    for (int i = 7; i > 0; i--) tick(1'b1, cb[i]);
    check("t4_inactive_before_end", {7'd0, active}, 8'd0);
    tick(1'b1, cb[0]);
    check("t4_active_at_end", {7'd0, active}, 8'd1);

    // reset mid-byte
    v = 8'h5A;
    for (int i = 7; i > 3; i--) tick(1'b1, v[i]);
    tick(1'b0, 1'b0);
    chk_zero("t5_after_reset");
    send_coms(3);
    for (int i = 7; i > 0; i--) tick(1'b1, cb[i]);
    check("t5_inactive_before_relock", {7'd0, active}, 8'd0);
    tick(1'b1, cb[0]);
    check("t5_relock", {7'd0, active}, 8'd1);

    // back-to-back data
    n_hits = 0;
    for (int b = 1; b <= 8; b++) begin
      v = 8'(b);
      for (int i = 7; i >= 0; i--) begin
        tick(1'b1, v[i]);
        if (byte_strobe) n_hits++;
        if (i == 0) begin
          check("t6_strobe_pos", {7'd0, byte_strobe}, 8'd1);
          check("t6_data", data_out, v);
        end else if (b > 1) begin
          check("t6_valid_held", {7'd0, valid_out}, 8'd1);
        end
      end
    end
    check("t6_strobe_count", n_hits[7:0], 8'd8);

    // randomized streams
    for (int r = 0; r < 40; r++) begin
      do_reset(1 + int'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 7)) tick(1'b1, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0)
        repeat ($urandom_range(8, 60)) tick(1'b1, 1'($urandom_range(0, 1)));
      send_coms(($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 3)) : LC);
      for (int b = 0; b < 12; b++) begin
        case ($urandom_range(0, 7))
          0: v = 8'hBC;
          1: v = 8'h7C;
          default: v = 8'($urandom);
        endcase
        if ($urandom_range(0, 15) == 0) begin
          for (int i = 7; i > 7 - int'($urandom_range(0, 7)); i--) tick(1'b1, v[i]);
          tick(1'b0, 1'b0);
          send_coms(LC);
        end else begin
          send_byte(v);
        end
      end
    end

    @(negedge clk_32f);
    chk_en = 0;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
